wfq_tag_engine: RTL and testbench
=================================

// Module: wfq_tag_engine
// PURPOSE
//  Parametrised WFQ finish-tag engine. Self-clocked fair queueing (SCFQ) with per-flow weight and backlog state.
//  Accepts packet arrivals over a valid/ready handshake and computes each finish tag as tag = max(V, F_last[f]) + len*inv_w[f].
//  Tracks system virtual time V from departures. Sits between the packet classifier and the sorted tag queue.
// PARAMETERS
//  DW      16  width of packet length, tags and virtual time
//  FLOW_W  4   flow-id width; NFLOWS = 2**FLOW_W
//  IW      8   width of programmable inverse weight inv_w
//  CNT_W   8   per-flow backlog counter width
//  MUL_LAT 2   pipeline stages in multiplier (>=1)
// PORTS
//  clk         in   1        clock
//  rst         in   1        synchronous, active-high reset
//  cfg_we      in   1        write inverse weight
//  cfg_flow    in   FLOW_W   flow to configure
//  cfg_inv_w   in   IW       inverse weight value
//  arr_valid   in   1        arrival request
//  arr_ready   out  1        arrival accepted when valid&ready
//  arr_flow    in   FLOW_W   arriving flow id
//  arr_len     in   DW       packet length
//  dep_valid   in   1        one-cycle departure strobe
//  dep_flow    in   FLOW_W   departing flow id
//  dep_tag     in   DW       finish tag of departing packet
//  tag_valid   out  1        result valid
//  tag_ready   in   1        downstream accepts result
//  tag_flow    out  FLOW_W   flow id of result
//  tag_len     out  DW       packet length, passed through
//  tag         out  DW       finish tag, saturated
//  tag_sat     out  1        tag was clipped to 2**DW-1
//  vtime       out  DW       current virtual time V
//  dep_err     out  1        sticky: departure seen on flow with zero backlog
// BEHAVIOUR
//  Reset: all outputs 0 except arr_ready=1.
//   Also clears V, F_last[], backlog[] and the pipeline; inv_w[] resets to 1.
//   Reset mid-operation drops in-flight packets with no tag emitted.
//  Pipeline: S0 read state -> MUL_LAT multiply stages -> S_add add/saturate/writeback -> output register.
//   Latency from accept to tag_valid is MUL_LAT+2 cycles when not stalled.
//  Stall: global enable en = ~tag_valid | tag_ready. All stages hold when en=0.
//   Output holds stable while tag_valid & ~tag_ready. Never drops or reorders results.
//  arr_ready = en & ~hazard. hazard = arr_flow matches any valid in-flight stage flow.
//   This is a same-flow RAW stall, no forwarding; other flows flow back-to-back at 1 per cycle.
//  Start tag S = (backlog[f]==0) ? V : max(V, F_last[f]). V is sampled at S0.
//  Product len*inv_w is DW+IW bits; sum is computed at DW+IW+1 bits.
//   If sum > 2**DW-1: tag = 2**DW-1 and tag_sat=1.
//  Writeback at S_add when it advances: F_last[f]<=tag, backlog[f]++.
//   backlog saturates at 2**CNT_W-1. At saturation the arrival is still tagged.
//  Departure (independent of en): V <= max(V, dep_tag); backlog[dep_flow]--.
//   If backlog is 0: no decrement, dep_err<=1.
//   Same-cycle writeback and departure on the same flow: net backlog change 0.
//  Busy-period end: when all backlog==0 and pipeline empty, V <= 0 on the next cycle.
//  cfg_we takes effect for arrivals accepted on the following cycle or later.
//   In-flight packets keep the weight they read.
//  Tags are unsigned; no wrap-around handling. Saturation is the only overflow policy.
// STRUCTURE
//  wfq_pkg: DW/FLOW_W/IW defaults, sat_add function, pipeline-stage struct {vld, flow, len, s}.
//  Sub-module wfq_mul_pipe: MUL_LAT-stage unsigned multiplier with enable, carrying the stage struct alongside.
//  State arrays (inv_w, F_last, backlog) are flop-based with NFLOWS entries; synchronous write, async read at S0.
// TESTING
//  1. Reset; cfg flow3 inv_w=4; arrive f3 len10 -> tag=40 after 4 cycles, tag_sat=0, vtime=0.
//  2. Next cycle arrive f3 len5 -> arr_ready=0 until first retires; then tag=60 (max(0,40)+20).
//  3. Depart f3 tag40 -> vtime=40; arrive f5 (inv_w=1) len7 -> tag=47.
//     Depart f3 again, then f5, then f3 -> dep_err=1; all idle -> vtime=0.
//  4. cfg f1 inv_w=255; arrive f1 len 0xFFFF -> tag=0xFFFF, tag_sat=1.
//  5. Hold tag_ready=0 for 10 cycles; offer f0,f1,f2 len 1,2,3 back-to-back -> tag_valid held.
//     Then tags 1,2,3 emerge in order, none lost, arr_ready low while full.
//  6. Assert rst with 3 packets in flight -> next cycle tag_valid=0, vtime=0.
//     Subsequent arrival on a previously backlogged flow uses S=0.

Source files
------------

// File: rtl/wfq_pkg.sv
// wfq_pkg: shared widths, pipeline-stage struct and saturating tag adder for the WFQ tag engine.
package wfq_pkg;
  localparam int DW = 16;
  localparam int FLOW_W = 4;
  localparam int IW = 8;
  localparam int NFLOWS = 2 ** FLOW_W;
  typedef struct packed {
    logic vld;
    logic [FLOW_W-1:0] flow;
    logic [DW-1:0] len;
    logic [DW-1:0] s;
  } stage_t;
  // Returns {sat, tag}; the sum is one bit wider than the product so nothing is lost before clipping.
  function automatic logic [DW:0] sat_add(input logic [DW-1:0] s, input logic [DW+IW-1:0] p);
    logic [DW+IW:0] sum;
    sum = {{(IW+1){1'b0}}, s} + {1'b0, p};
    return (|sum[DW+IW:DW]) ? {1'b1, {DW{1'b1}}} : {1'b0, sum[DW-1:0]};
  endfunction
endpackage

// File: rtl/wfq_mul_pipe.sv
// wfq_mul_pipe: LAT-stage unsigned len*inv_w multiplier carrying the stage struct alongside.
module wfq_mul_pipe import wfq_pkg::*; #(
  parameter int LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  stage_t            in,
  input  logic [DW-1:0]     a,
  input  logic [IW-1:0]     b,
  output stage_t            st [LAT],
  output logic [DW+IW-1:0]  p
);
  logic [DW+IW-1:0] pr [LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        st[i] <= '0;
        pr[i] <= '0;
      end
    end else if (en) begin
      st[0] <= in;
      pr[0] <= {{IW{1'b0}}, a} * {{DW{1'b0}}, b};
      for (int i = 1; i < LAT; i++) begin
        st[i] <= st[i-1];
        pr[i] <= pr[i-1];
      end
    end
  end
  assign p = pr[LAT-1];
endmodule

// File: rtl/wfq_tag_engine.sv
// wfq_tag_engine: SCFQ finish-tag engine, tag = max(V, F_last[f]) + len*inv_w[f], with per-flow backlog.
module wfq_tag_engine import wfq_pkg::*; #(
  parameter int CNT_W = 8,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [FLOW_W-1:0] cfg_flow,
  input  logic [IW-1:0]     cfg_inv_w,
  input  logic              arr_valid,
  output logic              arr_ready,
  input  logic [FLOW_W-1:0] arr_flow,
  input  logic [DW-1:0]     arr_len,
  input  logic              dep_valid,
  input  logic [FLOW_W-1:0] dep_flow,
  input  logic [DW-1:0]     dep_tag,
  output logic              tag_valid,
  input  logic              tag_ready,
  output logic [FLOW_W-1:0] tag_flow,
  output logic [DW-1:0]     tag_len,
  output logic [DW-1:0]     tag,
  output logic              tag_sat,
  output logic [DW-1:0]     vtime,
  output logic              dep_err
);
  logic [IW-1:0] inv_w [NFLOWS];
  logic [DW-1:0] f_last [NFLOWS];
  logic [CNT_W-1:0] backlog [NFLOWS];
  logic [DW-1:0] v;
  stage_t s0, a_q;
  stage_t m [MUL_LAT];
  logic [DW+IW-1:0] p, a_p;
  logic [DW:0] res;
  logic [NFLOWS-1:0] inc, dec;
  logic en, hazard, idle, wb;
  assign en = ~tag_valid | tag_ready;
  assign wb = en & a_q.vld;
  assign vtime = v;
  assign res = sat_add(a_q.s, a_p);
  // Same-flow RAW guard: F_last/backlog are only final once the packet leaves S_add.
  always_comb begin
    hazard = a_q.vld && a_q.flow == arr_flow;
    idle = ~a_q.vld & ~tag_valid;
    for (int i = 0; i < MUL_LAT; i++) begin
      hazard |= m[i].vld && m[i].flow == arr_flow;
      idle &= ~m[i].vld;
    end
    for (int i = 0; i < NFLOWS; i++) idle &= backlog[i] == '0;
  end
  assign arr_ready = en & ~hazard;
  assign s0 = '{
    vld: arr_valid & arr_ready,
    flow: arr_flow,
    len: arr_len,
    s: (backlog[arr_flow] == '0 || f_last[arr_flow] < v) ? v : f_last[arr_flow]
  };
  wfq_mul_pipe #(.LAT(MUL_LAT)) u_mul (
    .clk(clk), .rst(rst), .en(en), .in(s0), .a(arr_len), .b(inv_w[arr_flow]), .st(m), .p(p)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      a_p <= '0;
      tag_valid <= 1'b0;
      tag_flow <= '0;
      tag_len <= '0;
      tag <= '0;
      tag_sat <= 1'b0;
    end else if (en) begin
      a_q <= m[MUL_LAT-1];
      a_p <= p;
      tag_valid <= a_q.vld;
      tag_flow <= a_q.flow;
      tag_len <= a_q.len;
      {tag_sat, tag} <= res;
    end
  end
  // A writeback and a departure on the same flow cancel, so neither clamp nor dep_err applies.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NFLOWS; i++) begin
      inc[i] = wb && a_q.flow == FLOW_W'(i) && (backlog[i] != '1 || (dep_valid && dep_flow == FLOW_W'(i)));
      dec[i] = dep_valid && dep_flow == FLOW_W'(i) && (backlog[i] != '0 || (wb && a_q.flow == FLOW_W'(i)));
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      dep_err <= 1'b0;
      for (int i = 0; i < NFLOWS; i++) begin
        inv_w[i] <= IW'(1);
        f_last[i] <= '0;
        backlog[i] <= '0;
      end
    end else begin
      v <= idle ? '0 : (dep_valid && dep_tag > v) ? dep_tag : v;
      dep_err <= dep_err | (dep_valid & ~dec[dep_flow]);
      if (cfg_we) inv_w[cfg_flow] <= cfg_inv_w;
      if (wb) f_last[a_q.flow] <= res[DW-1:0];
      for (int i = 0; i < NFLOWS; i++) backlog[i] <= backlog[i] + CNT_W'(inc[i]) - CNT_W'(dec[i]);
    end
  end
endmodule

// File: tb/tb_wfq_tag_engine.sv
// tb_wfq_tag_engine: directed vectors with hand-computed tags for wfq_tag_engine.
module tb_wfq_tag_engine;
  import wfq_pkg::*;
  logic clk = 0, rst = 1;
  logic cfg_we = 0, arr_valid = 0, dep_valid = 0, tag_ready = 1;
  logic [FLOW_W-1:0] cfg_flow = '0, arr_flow = '0, dep_flow = '0;
  logic [IW-1:0] cfg_inv_w = '0;
  logic [DW-1:0] arr_len = '0, dep_tag = '0;
  logic arr_ready, tag_valid, tag_sat, dep_err;
  logic [FLOW_W-1:0] tag_flow;
  logic [DW-1:0] tag_len, tag, vtime;
  int checks = 0, failures = 0;
  wfq_tag_engine dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_flow(cfg_flow), .cfg_inv_w(cfg_inv_w),
    .arr_valid(arr_valid), .arr_ready(arr_ready), .arr_flow(arr_flow), .arr_len(arr_len),
    .dep_valid(dep_valid), .dep_flow(dep_flow), .dep_tag(dep_tag),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_flow(tag_flow), .tag_len(tag_len),
    .tag(tag), .tag_sat(tag_sat), .vtime(vtime), .dep_err(dep_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask
  task automatic cfg(input int f, input int w);
    cfg_we = 1;
    cfg_flow = FLOW_W'(f);
    cfg_inv_w = IW'(w);
    tick();
    cfg_we = 0;
  endtask
  task automatic depart(input int f, input int t);
    dep_valid = 1;
    dep_flow = FLOW_W'(f);
    dep_tag = DW'(t);
    tick();
    dep_valid = 0;
  endtask
  task automatic arrive(input string nm, input int f, input int len);
    int n = 0;
    arr_valid = 1;
    arr_flow = FLOW_W'(f);
    arr_len = DW'(len);
    #1;
    while (!arr_ready && n < 30) begin
      tick();
      n++;
    end
    chk({nm, "_rdy"}, 32'(arr_ready), 1);
    tick();
    arr_valid = 0;
  endtask
  task automatic wait_tag(input string nm);
    int n = 0;
    while (!tag_valid && n < 30) begin
      tick();
      n++;
    end
    chk({nm, "_seen"}, 32'(tag_valid), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    chk("rst_tv", 32'(tag_valid), 0);
    chk("rst_tag", 32'(tag), 0);
    chk("rst_vtime", 32'(vtime), 0);
    chk("rst_err", 32'(dep_err), 0);
    chk("rst_rdy", 32'(arr_ready), 1);
    // 1/2: latency 4 and same-flow RAW stall
    cfg(3, 4);
    arr_valid = 1;
    arr_flow = 3;
    arr_len = 10;
    #1 chk("t1_rdy", 32'(arr_ready), 1);
    tick();
    arr_len = 5;
    #1 chk("raw_a", 32'(arr_ready), 0);
    chk("lat_a", 32'(tag_valid), 0);
    tick();
    chk("raw_b", 32'(arr_ready), 0);
    tick();
    chk("raw_c", 32'(arr_ready), 0);
    chk("lat_c", 32'(tag_valid), 0);
    tick();
    chk("t1_tv", 32'(tag_valid), 1);
    chk("t1_tag", 32'(tag), 40);
    chk("t1_sat", 32'(tag_sat), 0);
    chk("t1_flow", 32'(tag_flow), 3);
    chk("t1_len", 32'(tag_len), 10);
    chk("t1_vtime", 32'(vtime), 0);
    chk("raw_free", 32'(arr_ready), 1);
    tick();
    arr_valid = 0;
    wait_tag("t2");
    chk("t2_tag", 32'(tag), 60);
    chk("t2_len", 32'(tag_len), 5);
    tick();
    // 3: virtual time from departures, dep_err, busy-period reset
    depart(3, 40);
    chk("t3_vtime40", 32'(vtime), 40);
    arrive("t3a", 5, 7);
    wait_tag("t3a");
    chk("t3_tag47", 32'(tag), 47);
    chk("t3_flow5", 32'(tag_flow), 5);
    tick();
    depart(3, 60);
    depart(5, 47);
    chk("t3_vtime60", 32'(vtime), 60);
    chk("t3_err0", 32'(dep_err), 0);
    depart(3, 0);
    chk("t3_err1", 32'(dep_err), 1);
    chk("t3_idle_v", 32'(vtime), 0);
    tick();
    chk("t3_err_sticky", 32'(dep_err), 1);
    // 4: saturation and exact-max boundary
    cfg(1, 255);
    arrive("t4a", 1, 16'hFFFF);
    wait_tag("t4a");
    chk("t4_sat_tag", 32'(tag), 32'hFFFF);
    chk("t4_sat", 32'(tag_sat), 1);
    tick();
    arrive("t4b", 2, 16'hFFFF);
    wait_tag("t4b");
    chk("t4_max_tag", 32'(tag), 32'hFFFF);
    chk("t4_max_sat", 32'(tag_sat), 0);
    tick();
    // 5: backpressure holds output, no loss or reorder
    do_reset();
    tag_ready = 0;
    for (int k = 0; k < 3; k++) begin
      arr_valid = 1;
      arr_flow = FLOW_W'(k);
      arr_len = DW'(k + 1);
      #1 chk("b2b_rdy", 32'(arr_ready), 1);
      tick();
    end
    arr_valid = 0;
    tick();
    arr_valid = 1;
    arr_flow = 3;
    arr_len = 4;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("hold_tv", 32'(tag_valid), 1);
      chk("hold_tag", 32'(tag), 1);
      chk("hold_rdy", 32'(arr_ready), 0);
      tick();
    end
    tag_ready = 1;
    #1 chk("f3_rdy", 32'(arr_ready), 1);
    for (int k = 0; k < 4; k++) begin
      wait_tag("drain");
      chk("drain_tag", 32'(tag), 32'(k + 1));
      chk("drain_flow", 32'(tag_flow), 32'(k));
      tick();
      arr_valid = 0;
    end
    chk("t5_vtime", 32'(vtime), 0);
    // 6: reset with packets in flight
    depart(0, 10);
    chk("t6_vtime10", 32'(vtime), 10);
    for (int k = 4; k < 7; k++) begin
      arr_valid = 1;
      arr_flow = FLOW_W'(k);
      arr_len = 8;
      #1 chk("t6_rdy", 32'(arr_ready), 1);
      tick();
    end
    arr_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    chk("t6_tv", 32'(tag_valid), 0);
    chk("t6_vtime", 32'(vtime), 0);
    chk("t6_err", 32'(dep_err), 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t6_dropped", 32'(tag_valid), 0);
    end
    arrive("t6b", 3, 2);
    wait_tag("t6b");
    chk("t6_s0_tag", 32'(tag), 2);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
